rsa_operand_loader: RTL and testbench

Parametrised UART receive front end for the RSA/RFID datapath. It deserialises 8N1 frames on rx and assembles NUM_OPS operands of WIDTH bits each, least-significant byte first. It presents the complete operand set to the modular-exponentiation core through a valid/ack handshake. It generalises the fixed 12-byte/32-bit loader with configurable width, operand count and baud divisor, and adds framing-error detection, inter-byte timeout, overrun reporting and abort.

---
 rtl/rsa_operand_loader.sv | 211 +++++++++++++++++++++
 tb/tb_rsa_operand_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa_operand_loader.sv
// UART (8N1) receive front end for the RSA/RFID datapath.
// Deserialises bytes and assembles NUM_OPS operands of WIDTH bits each,
// least-significant byte first, then hands the set to the core with a
// valid/ack handshake. Reports framing errors, inter-byte timeout and
// overrun as single-cycle pulses.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line idle; waiting for a high-to-low edge on the synced rx
// S_START | half-bit wait; confirm the start bit is still low
// S_DATA  | sample 8 data bits, LSB first, one per bit time
// S_STOP  | sample the stop bit; high = byte done, low = framing error
module rsa_operand_loader #(
   parameter int WIDTH        = 32,
   parameter int NUM_OPS      = 3,
   parameter int CLKS_PER_BIT = 5208,
   parameter int TIMEOUT_CLKS = 520800
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    rx,
   input  logic                                    abort,
   input  logic                                    ops_ack,
   output logic [NUM_OPS*WIDTH-1:0]                ops,
   output logic                                    ops_valid,
   output logic [$clog2(NUM_OPS*WIDTH/8+1)-1:0]    byte_cnt,
   output logic                                    frame_err,
   output logic                                    timeout,
   output logic                                    overrun
);

   localparam int TOTAL = NUM_OPS * WIDTH / 8;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int CLK_W = $clog2(CLKS_PER_BIT);
   localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [CLK_W-1:0] BIT_LOAD  = CLK_W'(CLKS_PER_BIT - 1);
   localparam logic [CLK_W-1:0] HALF_LOAD = CLK_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(TIMEOUT_CLKS - 1);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(TOTAL - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic                     r_rx_meta;
   logic                     r_rx_sync;
   logic                     r_rx_prev;
   logic [1:0]               r_state;
   logic [CLK_W-1:0]         r_clk_cnt;
   logic [2:0]               r_bit_cnt;
   logic [7:0]               r_shift;
   logic [NUM_OPS*WIDTH-1:0] r_ops;
   logic                     r_ops_valid;
   logic [CNT_W-1:0]         r_byte_cnt;
   logic [TO_W-1:0]          r_to_cnt;
   logic                     r_frame_err;
   logic                     r_timeout;
   logic                     r_overrun;

   logic w_stop_tick;
   logic w_byte_done;
   logic w_frame_evt;
   logic w_ack;
   logic w_valid_held;
   logic w_to_run;

   // A stop-bit sample point either completes a byte or flags a framing error.
   assign w_stop_tick  = (r_state == S_STOP) && (r_clk_cnt == '0);
   assign w_byte_done  = w_stop_tick &&  r_rx_sync;
   assign w_frame_evt  = w_stop_tick && !r_rx_sync;
   // An ack in the same cycle frees the holding register before the byte lands.
   assign w_ack        = r_ops_valid && ops_ack;
   assign w_valid_held = r_ops_valid && !ops_ack;
   assign w_to_run     = (r_byte_cnt != '0) && (r_state == S_IDLE) && !r_ops_valid;

   // Two-flop synchroniser plus a delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // Receiver FSM: bit timing via a down-counter reloaded at each sample point.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else if (abort) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Edge detect means a low line after a framing error must
               // first return high before the receiver can re-arm.
               if (r_rx_prev && !r_rx_sync) begin
                  r_state   <= S_START;
                  r_clk_cnt <= HALF_LOAD;
                  r_bit_cnt <= '0;
               end
            end
            S_START: begin
               if (r_clk_cnt == '0) begin
                  if (!r_rx_sync) begin
                     r_state   <= S_DATA;
                     r_clk_cnt <= BIT_LOAD;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt - 1'b1;
               end
            end
            S_DATA: begin
               if (r_clk_cnt == '0) begin
                  r_shift   <= {r_rx_sync, r_shift[7:1]};
                  r_clk_cnt <= BIT_LOAD;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt - 1'b1;
               end
            end
            S_STOP: begin
               if (r_clk_cnt == '0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_clk_cnt <= r_clk_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Assembler, handshake, inter-byte timeout and status pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ops       <= '0;
         r_ops_valid <= 1'b0;
         r_byte_cnt  <= '0;
         r_to_cnt    <= TO_LOAD;
         r_frame_err <= 1'b0;
         r_timeout   <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         r_timeout   <= 1'b0;
         r_overrun   <= 1'b0;
         if (abort) begin
            r_byte_cnt  <= '0;
            r_ops_valid <= 1'b0;
            r_to_cnt    <= TO_LOAD;
         end else begin
            if (w_ack) begin
               r_ops_valid <= 1'b0;
            end
            if (w_frame_evt) begin
               r_frame_err <= 1'b1;
               r_byte_cnt  <= '0;
               r_to_cnt    <= TO_LOAD;
            end else if (w_byte_done) begin
               r_to_cnt <= TO_LOAD;
               if (w_valid_held) begin
                  r_overrun <= 1'b1;
               end else begin
                  for (int i = 0; i < TOTAL; i++) begin
                     if (r_byte_cnt == CNT_W'(i)) begin
                        r_ops[i*8 +: 8] <= r_shift;
                     end
                  end
                  if (r_byte_cnt == LAST_BYTE) begin
                     r_ops_valid <= 1'b1;
                     r_byte_cnt  <= '0;
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end
               end
            end else if (w_to_run) begin
               // Paused (not reloaded) while a frame is in flight.
               if (r_to_cnt == '0) begin
                  r_timeout  <= 1'b1;
                  r_byte_cnt <= '0;
                  r_to_cnt   <= TO_LOAD;
               end else begin
                  r_to_cnt <= r_to_cnt - 1'b1;
               end
            end
         end
      end
   end

   assign ops       = r_ops;
   assign ops_valid = r_ops_valid;
   assign byte_cnt  = r_byte_cnt;
   assign frame_err = r_frame_err;
   assign timeout   = r_timeout;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Bench for rsa_operand_loader: one 3x32-bit instance and one 2x64-bit
// instance, both with a short bit time so the run stays small.
module tb_rsa_operand_loader;

   localparam int CPB  = 16;
   localparam int TOCL = 1600;

   logic clk;
   logic rst_n;
   logic rx_a, abort_a, ack_a;
   logic rx_b, abort_b, ack_b;

   logic [95:0]  ops_a;
   logic         valid_a, fe_a, to_a, ov_a;
   logic [3:0]   bcnt_a;
   logic [127:0] ops_b;
   logic         valid_b, fe_b, to_b, ov_b;
   logic [4:0]   bcnt_b;

   rsa_operand_loader #(.WIDTH(32), .NUM_OPS(3), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TOCL)) dut_a (
      .clk(clk), .reset(rst_n), .rx(rx_a), .abort(abort_a), .ops_ack(ack_a),
      .ops(ops_a), .ops_valid(valid_a), .byte_cnt(bcnt_a),
      .frame_err(fe_a), .timeout(to_a), .overrun(ov_a));

   rsa_operand_loader #(.WIDTH(64), .NUM_OPS(2), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TOCL)) dut_b (
      .clk(clk), .reset(rst_n), .rx(rx_b), .abort(abort_b), .ops_ack(ack_b),
      .ops(ops_b), .ops_valid(valid_b), .byte_cnt(bcnt_b),
      .frame_err(fe_b), .timeout(to_b), .overrun(ov_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int n_fe = 0, n_to = 0, n_ov = 0;
   int n_err_b = 0;
   logic [127:0] exp_q[$];
   logic [127:0] last_exp;

   // Pulse counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (fe_a) n_fe++;
      if (to_a) n_to++;
      if (ov_a) n_ov++;
      if (fe_b || to_b || ov_b) n_err_b++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_rx(input int which, input logic v);
      if (which == 0) rx_a = v;
      else            rx_b = v;
   endtask

   task automatic send_byte(input int which, input logic [7:0] b, input logic stop_bit);
      set_rx(which, 1'b0);
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_rx(which, b[i]);
         repeat (CPB) @(negedge clk);
      end
      set_rx(which, stop_bit);
      repeat (CPB) @(negedge clk);
      set_rx(which, 1'b1);
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_set(input int which, input logic [127:0] v, input int nbytes);
      exp_q.push_back(v);
      for (int i = 0; i < nbytes; i++) send_byte(which, v[i*8 +: 8], 1'b1);
   endtask

   task automatic expect_set(input int which, input string tag);
      bit ok;
      logic [127:0] got;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ((which == 0) ? valid_a : valid_b) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_valid"}, 128'(ok), 128'd1);
      last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      got = (which == 0) ? 128'(ops_a) : ops_b;
      check({tag, "_ops"}, got, last_exp);
      check({tag, "_bcnt"}, (which == 0) ? 128'(bcnt_a) : 128'(bcnt_b), 128'd0);
   endtask

   task automatic pulse_ack_a();
      ack_a = 1'b1;
      @(negedge clk);
      ack_a = 1'b0;
   endtask

   logic [127:0] v;
   int fe0, to0, ov0;
   bit seen;

   initial begin
      rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
      abort_a = 1'b0; abort_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ops_a",   128'(ops_a), 128'd0);
      check("rst_valid_a", 128'(valid_a), 128'd0);
      check("rst_bcnt_a",  128'(bcnt_a), 128'd0);
      check("rst_pulses_a", 128'({fe_a, to_a, ov_a}), 128'd0);
      check("rst_ops_b",   ops_b, 128'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Known-answer set: 01 00 01 00 FD 8D 00 00 05 00 00 00
      send_set(0, 128'h00000005_00008DFD_00010001, 12);
      expect_set(0, "kat");
      check("kat_no_err", 128'(n_fe + n_to + n_ov), 128'd0);

      // Extra byte while the set is held: dropped, overrun once.
      send_byte(0, 8'hAA, 1'b1);
      check("ovr_count", 128'(n_ov), 128'd1);
      check("ovr_ops",   128'(ops_a), last_exp);
      check("ovr_valid", 128'(valid_a), 128'd1);
      pulse_ack_a();
      check("ack_valid", 128'(valid_a), 128'd0);
      check("ack_hold",  128'(ops_a), last_exp);

      // Partial set then idle: timeout after TOCL idle clocks.
      for (int i = 0; i < 5; i++) send_byte(0, 8'(8'h30 + i), 1'b1);
      check("to_bcnt5", 128'(bcnt_a), 128'd5);
      repeat (1500) @(negedge clk);
      check("to_early", 128'(bcnt_a), 128'd5);
      to0 = n_to;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (n_to != to0) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      check("to_seen",  128'(seen), 128'd1);
      check("to_bcnt0", 128'(bcnt_a), 128'd0);
      repeat (20) @(negedge clk);
      check("to_once",  128'(n_to), 128'd1);
      v = 128'({$urandom, $urandom, $urandom});
      send_set(0, v, 12);
      expect_set(0, "after_to");
      pulse_ack_a();

      // Three good bytes, then a frame with a low stop bit.
      fe0 = n_fe; to0 = n_to;
      for (int i = 0; i < 3; i++) send_byte(0, 8'(8'hC0 + i), 1'b1);
      check("fe_bcnt3", 128'(bcnt_a), 128'd3);
      send_byte(0, 8'h5A, 1'b0);
      check("fe_count", 128'(n_fe - fe0), 128'd1);
      check("fe_bcnt0", 128'(bcnt_a), 128'd0);
      check("fe_no_to", 128'(n_to - to0), 128'd0);
      v = 128'({$urandom, $urandom, $urandom});
      send_set(0, v, 12);
      expect_set(0, "after_fe");
      pulse_ack_a();

      // Quarter-bit glitch on the idle line: ignored.
      fe0 = n_fe;
      rx_a = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx_a = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch_bcnt", 128'(bcnt_a), 128'd0);
      check("glitch_fe",   128'(n_fe - fe0), 128'd0);
      check("glitch_valid", 128'(valid_a), 128'd0);

      // Abort after seven bytes.
      for (int i = 0; i < 7; i++) send_byte(0, 8'(8'h70 + i), 1'b1);
      check("abort_bcnt7", 128'(bcnt_a), 128'd7);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      check("abort_bcnt0", 128'(bcnt_a), 128'd0);
      v = 128'({$urandom, $urandom, $urandom});
      send_set(0, v, 12);
      expect_set(0, "after_abort");
      check("final_ov", 128'(n_ov), 128'd1);

      // Wide instance: bytes 00..0F.
      send_set(1, 128'h0F0E0D0C0B0A0908_0706050403020100, 16);
      expect_set(1, "wide");
      check("wide_no_err", 128'(n_err_b), 128'd0);

      // Reset mid-frame: outputs clear without waiting for a clock edge.
      rx_b = 1'b0;
      repeat (CPB + 4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ops_b",   ops_b, 128'd0);
      check("arst_valid_b", 128'(valid_b), 128'd0);
      check("arst_bcnt_b",  128'(bcnt_b), 128'd0);
      check("arst_ops_a",   128'(ops_a), 128'd0);
      check("arst_valid_a", 128'(valid_a), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
